// File: rtl/renkon_ctrl_pool_stride.sv
// renkon pooling controller: raster scan with configurable window/stride, hit marking,
// D_POOL-deep start/valid/stop alignment and sticky config error. Optional macro: RENKON_POOL_PAD_EN.
module renkon_ctrl_pool_stride #(
  parameter int LWIDTH   = 12,
  parameter int DWIDTH   = 6,
  parameter int D_POOL   = 7,
  parameter int MAX_POOL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pool_en,
  input  logic                  in_start,
  input  logic                  in_valid,
  input  logic                  in_stop,
  input  logic [DWIDTH-1:0]     in_delay,
  input  logic [LWIDTH-1:0]     cfg_fea_size,
  input  logic [LWIDTH-1:0]     cfg_pool_size,
  input  logic [LWIDTH-1:0]     cfg_stride,
`ifdef RENKON_POOL_PAD_EN
  input  logic [LWIDTH-1:0]     cfg_pad,
`endif
  output logic                  out_start,
  output logic                  out_valid,
  output logic                  out_stop,
  output logic [DWIDTH-1:0]     out_delay,
  output logic                  pool_oe,
  output logic                  busy,
  output logic                  cfg_err,
  output logic [2*LWIDTH-1:0]   win_cnt
);

  localparam int DRW = $clog2(D_POOL + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_e;

  state_e              state_q;
  logic [LWIDTH-1:0]   fea_q, pool_q, stride_q, pad_q;
  logic [LWIDTH-1:0]   col_q, row_q, phx_q, phy_q;
  logic [LWIDTH-1:0]   col_d, row_d, phx_d, phy_d;
  logic [LWIDTH-1:0]   org, pad_in;
  logic [D_POOL-1:0]   vld_q, sta_q, stp_q;
  logic [DRW-1:0]      drn_q;
  logic                byp_sta_q, byp_vld_q, byp_stp_q;
  logic [2*LWIDTH-1:0] win_q;
  logic                err_q;
  logic                latch, acc, last, hit, err_in, col_wrap;

`ifdef RENKON_POOL_PAD_EN
  assign pad_in = cfg_pad;
`else
  assign pad_in = '0;
`endif

  assign latch = (state_q == S_IDLE) && in_start && pool_en;
  assign acc   = (state_q == S_ACTIVE) && in_valid;
  assign last  = acc && (col_q == fea_q - LWIDTH'(1)) && (row_q == fea_q - LWIDTH'(1));

  // Lattice origin: first column/row whose window is fully inside the padded map.
  assign org = pool_q - LWIDTH'(1) - pad_q;
  assign hit = acc && !err_q && (col_q >= org) && (phx_q == '0)
                              && (row_q >= org) && (phy_q == '0);

  assign err_in = (cfg_pool_size == '0) || (cfg_stride == '0)
               || (cfg_pool_size > cfg_fea_size)
               || (cfg_pool_size > LWIDTH'(MAX_POOL))
               || (pad_in >= cfg_pool_size);

  // Phase counters track the phase of the pixel at col_q/row_q; reset at the origin.
  always_comb begin
    col_wrap = (col_q == fea_q - LWIDTH'(1));
    col_d    = col_wrap ? '0 : col_q + LWIDTH'(1);
    row_d    = col_wrap ? row_q + LWIDTH'(1) : row_q;
    phx_d    = (col_d == org) ? '0 :
               (phx_q == stride_q - LWIDTH'(1)) ? '0 : phx_q + LWIDTH'(1);
    phy_d    = phy_q;
    if (col_wrap) begin
      phy_d = (row_d == org) ? '0 :
              (phy_q == stride_q - LWIDTH'(1)) ? '0 : phy_q + LWIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fea_q     <= '0;
      pool_q    <= '0;
      stride_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      phx_q     <= '0;
      phy_q     <= '0;
      vld_q     <= '0;
      sta_q     <= '0;
      stp_q     <= '0;
      drn_q     <= '0;
      byp_sta_q <= 1'b0;
      byp_vld_q <= 1'b0;
      byp_stp_q <= 1'b0;
      win_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      byp_sta_q <= in_start;
      byp_vld_q <= in_valid;
      byp_stp_q <= in_stop;
      vld_q     <= {vld_q[D_POOL-2:0], hit};
      sta_q     <= {sta_q[D_POOL-2:0], latch};
      stp_q     <= {stp_q[D_POOL-2:0], last};
      if (vld_q[0]) win_q <= win_q + (2*LWIDTH)'(1);
      case (state_q)
        S_IDLE: begin
          if (latch) begin
            fea_q    <= cfg_fea_size;
            pool_q   <= cfg_pool_size;
            stride_q <= cfg_stride;
            col_q    <= '0;
            row_q    <= '0;
            phx_q    <= '0;
            phy_q    <= '0;
            win_q    <= '0;
            err_q    <= err_in;
            state_q  <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (acc) begin
            col_q <= col_d;
            row_q <= row_d;
            phx_q <= phx_d;
            phy_q <= phy_d;
          end
          if (last) begin
            drn_q   <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drn_q <= drn_q + DRW'(1);
          if (drn_q == DRW'(D_POOL - 1)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef RENKON_POOL_PAD_EN
  always_ff @(posedge clk) begin
    if (rst)        pad_q <= '0;
    else if (latch) pad_q <= cfg_pad;
  end
`else
  assign pad_q = '0;
`endif

  assign out_start = pool_en ? sta_q[D_POOL-1] : byp_sta_q;
  assign out_valid = pool_en ? vld_q[D_POOL-1] : byp_vld_q;
  assign out_stop  = pool_en ? stp_q[D_POOL-1] : byp_stp_q;
  assign pool_oe   = pool_en & vld_q[D_POOL-2];
  assign out_delay = in_delay + (pool_en ? DWIDTH'(D_POOL) : DWIDTH'(1));
  assign busy      = (state_q != S_IDLE);
  assign cfg_err   = err_q;
  assign win_cnt   = win_q;

endmodule

// File: tb/tb_renkon_ctrl_pool_stride.sv
// Directed bench for renkon_ctrl_pool_stride: frames with hand-derived window positions,
// bypass mode, illegal config and mid-frame reset.
module tb_renkon_ctrl_pool_stride;
  localparam int LW = 12;
  localparam int DW = 6;
  localparam int D  = 7;

  logic          clk = 1'b0;
  logic          rst, pool_en, in_start, in_valid, in_stop;
  logic [DW-1:0] in_delay;
  logic [LW-1:0] fea, psz, strd;
  logic          out_start, out_valid, out_stop, pool_oe, busy, cfg_err;
  logic [DW-1:0] out_delay;
  logic [2*LW-1:0] win_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int q_vld[$], q_sta[$], q_stp[$], q_oe[$];
  int cs;

  renkon_ctrl_pool_stride #(.LWIDTH(LW), .DWIDTH(DW), .D_POOL(D), .MAX_POOL(4)) dut (
    .clk(clk), .rst(rst), .pool_en(pool_en), .in_start(in_start), .in_valid(in_valid),
    .in_stop(in_stop), .in_delay(in_delay), .cfg_fea_size(fea), .cfg_pool_size(psz),
    .cfg_stride(strd),
`ifdef RENKON_POOL_PAD_EN
    .cfg_pad('0),
`endif
    .out_start(out_start), .out_valid(out_valid), .out_stop(out_stop),
    .out_delay(out_delay), .pool_oe(pool_oe), .busy(busy), .cfg_err(cfg_err),
    .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) q_vld.push_back(cyc);
    if (out_start) q_sta.push_back(cyc);
    if (out_stop)  q_stp.push_back(cyc);
    if (pool_oe)   q_oe.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit hit_model(int k, int f, int p, int s);
    int r, c;
    r = k / f;
    c = k % f;
    return (c >= p - 1) && (r >= p - 1) && ((c - p + 1) % s == 0) && ((r - p + 1) % s == 0);
  endfunction

  task automatic clear_q();
    q_vld.delete(); q_sta.delete(); q_stp.delete(); q_oe.delete();
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " idle"}, busy, 0);
  endtask

  task automatic start_frame(input int f, input int p, input int s, output int cs_o);
    @(negedge clk);
    clear_q();
    pool_en = 1'b1; fea = LW'(f); psz = LW'(p); strd = LW'(s);
    in_delay = 6'd9; in_start = 1'b1;
    cs_o = cyc + 1;
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic run_frame(input int f, input int p, input int s, input bit bad,
                           input string nm, output int cs_o);
    int exp_q[$];
    int n;
    n = f * f;
    start_frame(f, p, s, cs_o);
    chk({nm, " busy"}, busy, 1);
    chk({nm, " err"}, cfg_err, bad);
    chk({nm, " odly"}, out_delay, 16);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle(nm);
    repeat (3) @(negedge clk);
    if (!bad)
      for (int k = 0; k < n; k++)
        if (hit_model(k, f, p, s)) exp_q.push_back(cs_o + k + D);
    chk({nm, " nvld"}, q_vld.size(), exp_q.size());
    chk({nm, " noe"}, q_oe.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q_vld.size() && i < q_oe.size(); i++) begin
      chk({nm, " vcyc"}, q_vld[i], exp_q[i]);
      chk({nm, " oecyc"}, q_oe[i], exp_q[i] - 1);
    end
    chk({nm, " nsta"}, q_sta.size(), 1);
    chk({nm, " stacyc"}, (q_sta.size() > 0) ? q_sta[0] : -1, cs_o + D - 1);
    chk({nm, " nstp"}, q_stp.size(), 1);
    chk({nm, " stpcyc"}, (q_stp.size() > 0) ? q_stp[0] : -1, cs_o + n + D - 1);
    chk({nm, " wcnt"}, win_cnt, exp_q.size());
  endtask

  initial begin
    int bexp[$];
    bit [3:0] pat;
    rst = 1'b1; pool_en = 1'b0; in_start = 1'b0; in_valid = 1'b0; in_stop = 1'b0;
    in_delay = '0; fea = '0; psz = '0; strd = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst vld", out_valid, 0);
    chk("rst sta", out_start, 0);
    chk("rst stp", out_stop, 0);
    chk("rst oe", pool_oe, 0);
    chk("rst err", cfg_err, 0);
    chk("rst wcnt", win_cnt, 0);
    rst = 1'b0;

    // out_delay is combinational and wraps modulo 64
    in_delay = 6'd60; pool_en = 1'b1;
    #1 chk("dly wrap pool", out_delay, 3);
    in_delay = 6'd63; pool_en = 1'b0;
    #1 chk("dly wrap byp", out_delay, 0);

    run_frame(8, 2, 2, 1'b0, "t1", cs);
    chk("t1 n16", q_vld.size(), 16);
    run_frame(8, 3, 1, 1'b0, "t2", cs);
    chk("t2 n36", q_vld.size(), 36);
    chk("t2 first", (q_vld.size() > 0) ? q_vld[0] : -1, cs + 18 + D);
    run_frame(7, 3, 2, 1'b0, "t3", cs);
    chk("t3 n9", q_vld.size(), 9);
    run_frame(8, 2, 3, 1'b0, "tskip", cs);
    chk("tskip n9", q_vld.size(), 9);
    run_frame(3, 1, 1, 1'b0, "tp1", cs);

    // bypass: outputs are inputs registered once
    @(negedge clk);
    clear_q();
    pool_en = 1'b0; in_delay = 6'd5;
    pat = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      in_valid = pat[i];
      in_start = (i == 0);
      in_stop  = (i == 3);
      if (pat[i]) bexp.push_back(cyc + 1);
      @(negedge clk);
      chk("t4 odly", out_delay, 6);
      chk("t4 busy", busy, 0);
    end
    in_valid = 1'b0; in_start = 1'b0; in_stop = 1'b0;
    @(negedge clk);
    chk("t4 nvld", q_vld.size(), 3);
    for (int i = 0; i < bexp.size() && i < q_vld.size(); i++) chk("t4 vcyc", q_vld[i], bexp[i]);
    chk("t4 sta", (q_sta.size() > 0) ? q_sta[0] : -1, bexp[0]);
    chk("t4 stp", (q_stp.size() > 0) ? q_stp[0] : -1, bexp[2]);
    chk("t4 noe", q_oe.size(), 0);

    run_frame(4, 5, 1, 1'b1, "t5", cs);
    chk("t5 sticky", cfg_err, 1);
    run_frame(4, 0, 1, 1'b1, "t5z", cs);
    run_frame(4, 2, 2, 1'b0, "t5ok", cs);

    // reset at pixel 30 of a 64-pixel frame
    start_frame(8, 2, 2, cs);
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6 busy", busy, 0);
    chk("t6 vld", out_valid, 0);
    chk("t6 sta", out_start, 0);
    chk("t6 stp", out_stop, 0);
    chk("t6 wcnt", win_cnt, 0);
    clear_q();
    repeat (12) @(negedge clk);
    chk("t6 nostp", q_stp.size(), 0);
    chk("t6 novld", q_vld.size(), 0);
    run_frame(8, 2, 2, 1'b0, "t6new", cs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
